axi_burst_write_slave: RTL

AXI_BURST_WRITE_SLAVE -- requirements
Module: axi_burst_write_slave

---
 rtl/axi_burst_write_slave_if.sv | 50 +++++
 rtl/axi_burst_write_slave.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_write_slave_if.sv
// AXI3-style write channel bundle (AW, W, B) between a burst master and
// axi_burst_write_slave. Signal names follow the AXI channel naming.
interface axi_burst_write_slave_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int ID_W   = 4
) ();

   // Write-address channel
   logic [ID_W-1:0]     AWID;
   logic [ADDR_W-1:0]   AWADDR;
   logic [3:0]          AWLEN;
   logic [2:0]          AWSIZE;
   logic [1:0]          AWBURST;
   logic                AWVALID;
   logic                AWREADY;

   // Write-data channel
   logic [ID_W-1:0]     WID;
   logic [DATA_W-1:0]   WDATA;
   logic [DATA_W/8-1:0] WSTRB;
   logic                WLAST;
   logic                WVALID;
   logic                WREADY;

   // Write-response channel
   logic [ID_W-1:0]     BID;
   logic [1:0]          BRESP;
   logic                BVALID;
   logic                BREADY;

   modport master (
      output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
      input  AWREADY,
      output WID, WDATA, WSTRB, WLAST, WVALID,
      input  WREADY,
      input  BID, BRESP, BVALID,
      output BREADY
   );

   modport slave (
      input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
      output AWREADY,
      input  WID, WDATA, WSTRB, WLAST, WVALID,
      output WREADY,
      output BID, BRESP, BVALID,
      input  BREADY
   );

endinterface

// File: rtl/axi_burst_write_slave.sv
// AXI burst write slave: accepts one write burst at a time, forwards each
// accepted beat to a simple device port one cycle later, and returns a single
// B response (OKAY or SLVERR) once the beat counter reaches AWLEN.
//
// Build option: define AXI_WSLV_WRAP_EN to support WRAP bursts. Without it a
// WRAP burst is accepted but flagged SLVERR and never written to the device.
module axi_burst_write_slave #(
   parameter int DATA_W = 32,   // 32, 64 or 128
   parameter int ADDR_W = 32,
   parameter int ID_W   = 4
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   axi_burst_write_slave_if.slave  axi,
   output logic                    dev_wen,
   output logic [ADDR_W-1:0]       dev_addr,
   output logic [DATA_W-1:0]       dev_wdata,
   output logic [DATA_W/8-1:0]     dev_wstrb,
   input  logic                    dev_ready
);

   localparam int STRB_W = DATA_W / 8;

   // Largest legal AWSIZE: one beat may not exceed the data bus width.
   localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_W));

   localparam logic [ADDR_W-1:0] ONE_A  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      DATA = 2'b01,
      RESP = 2'b10
   } state_t;

   // Configuration error for a new burst: oversized beats, the reserved burst
   // type, or a WRAP burst that is illegal (or unsupported in this build).
   function automatic logic aw_cfg_error(input logic [2:0] size,
                                         input logic [1:0] burst,
                                         input logic       wrap_bad);
      logic err;
      err = (size > MAX_SIZE);
      case (burst)
         BURST_FIXED: err = err;
         BURST_INCR:  err = err;
         BURST_WRAP:  err = err | wrap_bad;
         default:     err = 1'b1;
      endcase
      return err;
   endfunction

   // ------------------------------------------------------------------
   // State and burst context
   // ------------------------------------------------------------------
   state_t              state_r;
   state_t              state_s;

   logic [ID_W-1:0]     id_r;
   logic [ADDR_W-1:0]   addr_r;
   logic [3:0]          len_r;
   logic [2:0]          size_r;
   logic [1:0]          burst_r;
   logic [3:0]          cnt_r;
   logic                err_r;       // sticky per-beat protocol error
   logic                cfg_err_r;   // burst-wide error: no device writes

   logic                awready_r;
   logic                bvalid_r;
   logic [1:0]          bresp_r;
   logic [ID_W-1:0]     bid_r;

   logic                dev_wen_r;
   logic [ADDR_W-1:0]   dev_addr_r;
   logic [DATA_W-1:0]   dev_wdata_r;
   logic [STRB_W-1:0]   dev_wstrb_r;

   // Handshake and decode terms
   logic                aw_hs_s;
   logic                wready_s;
   logic                beat_s;
   logic                last_s;
   logic                beat_err_s;
   logic                wrap_bad_s;

   // Address sequencing
   logic [ADDR_W-1:0]   size_bytes_s;
   logic [ADDR_W-1:0]   aligned_s;
   logic [ADDR_W-1:0]   incr_s;
   logic [ADDR_W-1:0]   addr_next_s;
`ifdef AXI_WSLV_WRAP_EN
   logic [ADDR_W-1:0]   wrap_bytes_s;
   logic [ADDR_W-1:0]   wrap_mask_s;
   logic [ADDR_W-1:0]   wrap_s;
   logic [ADDR_W-1:0]   aw_size_mask_s;
`endif

   // Legality of an incoming WRAP burst: power-of-two length of 2..16 beats
   // and a start address aligned to the beat size.
`ifdef AXI_WSLV_WRAP_EN
   always_comb begin
      aw_size_mask_s = (ONE_A << axi.AWSIZE) - ONE_A;
      wrap_bad_s     = 1'b0;
      if (!((axi.AWLEN == 4'd1) || (axi.AWLEN == 4'd3) ||
            (axi.AWLEN == 4'd7) || (axi.AWLEN == 4'd15))) begin
         wrap_bad_s = 1'b1;
      end else if ((axi.AWADDR & aw_size_mask_s) != ZERO_A) begin
         wrap_bad_s = 1'b1;
      end else begin
         wrap_bad_s = 1'b0;
      end
   end
`else
   // WRAP bursts are not supported in this build and always flag an error.
   always_comb begin
      wrap_bad_s = 1'b1;
   end
`endif

   // Next-state logic and handshake decode for the IDLE/DATA/RESP machine.
   always_comb begin
      state_s    = state_r;
      aw_hs_s    = 1'b0;
      wready_s   = 1'b0;
      beat_s     = 1'b0;
      last_s     = (cnt_r == len_r);
      beat_err_s = (axi.WLAST != last_s) || (axi.WID != id_r);
      case (state_r)
         IDLE: begin
            aw_hs_s = axi.AWVALID && awready_r;
            if (aw_hs_s) begin
               state_s = DATA;
            end else begin
               state_s = IDLE;
            end
         end
         DATA: begin
            wready_s = dev_ready;
            beat_s   = axi.WVALID && dev_ready;
            // Only the beat counter ends the burst; WLAST merely checks it.
            if (beat_s && last_s) begin
               state_s = RESP;
            end else begin
               state_s = DATA;
            end
         end
         RESP: begin
            if (bvalid_r && axi.BREADY) begin
               state_s = IDLE;
            end else begin
               state_s = RESP;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Address of the following beat for the latched burst type.
   always_comb begin
      size_bytes_s = ONE_A << size_r;
      aligned_s    = addr_r & ~(size_bytes_s - ONE_A);
      incr_s       = aligned_s + size_bytes_s;
`ifdef AXI_WSLV_WRAP_EN
      wrap_bytes_s = size_bytes_s * ({{(ADDR_W-4){1'b0}}, len_r} + ONE_A);
      wrap_mask_s  = wrap_bytes_s - ONE_A;
      wrap_s       = (addr_r & ~wrap_mask_s) | (incr_s & wrap_mask_s);
`endif
      case (burst_r)
         BURST_INCR:  addr_next_s = incr_s;
`ifdef AXI_WSLV_WRAP_EN
         BURST_WRAP:  addr_next_s = wrap_s;
`endif
         default:     addr_next_s = addr_r;
      endcase
   end

   // FSM state register.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Burst context: latched on the AW handshake, advanced on each beat.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         id_r      <= {ID_W{1'b0}};
         addr_r    <= ZERO_A;
         len_r     <= 4'd0;
         size_r    <= 3'd0;
         burst_r   <= 2'b00;
         cnt_r     <= 4'd0;
         err_r     <= 1'b0;
         cfg_err_r <= 1'b0;
      end else if (aw_hs_s) begin
         id_r      <= axi.AWID;
         addr_r    <= axi.AWADDR;
         len_r     <= axi.AWLEN;
         size_r    <= axi.AWSIZE;
         burst_r   <= axi.AWBURST;
         cnt_r     <= 4'd0;
         err_r     <= 1'b0;
         cfg_err_r <= aw_cfg_error(axi.AWSIZE, axi.AWBURST, wrap_bad_s);
      end else if (beat_s) begin
         addr_r    <= addr_next_s;
         cnt_r     <= cnt_r + 4'd1;
         err_r     <= err_r | beat_err_s;
      end else begin
         cnt_r     <= cnt_r;
         err_r     <= err_r;
      end
   end

   // Registered AW ready and B channel; the response is frozen on the last beat
   // and held until the master takes it.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         awready_r <= 1'b0;
         bvalid_r  <= 1'b0;
         bresp_r   <= RESP_OKAY;
         bid_r     <= {ID_W{1'b0}};
      end else begin
         awready_r <= (state_s == IDLE);
         bvalid_r  <= (state_s == RESP);
         if (beat_s && last_s) begin
            bresp_r <= (err_r || beat_err_s || cfg_err_r) ? RESP_SLVERR : RESP_OKAY;
            bid_r   <= id_r;
         end else begin
            bresp_r <= bresp_r;
            bid_r   <= bid_r;
         end
      end
   end

   // Device write port: one-cycle registered copy of each accepted beat,
   // suppressed entirely for bursts with a configuration error.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         dev_wen_r   <= 1'b0;
         dev_addr_r  <= ZERO_A;
         dev_wdata_r <= {DATA_W{1'b0}};
         dev_wstrb_r <= {STRB_W{1'b0}};
      end else if (beat_s && !cfg_err_r) begin
         dev_wen_r   <= 1'b1;
         dev_addr_r  <= addr_r;
         dev_wdata_r <= axi.WDATA;
         dev_wstrb_r <= axi.WSTRB;
      end else begin
         dev_wen_r   <= 1'b0;
      end
   end

   assign axi.AWREADY = awready_r;
   assign axi.WREADY  = wready_s;
   assign axi.BVALID  = bvalid_r;
   assign axi.BRESP   = bresp_r;
   assign axi.BID     = bid_r;

   assign dev_wen     = dev_wen_r;
   assign dev_addr    = dev_addr_r;
   assign dev_wdata   = dev_wdata_r;
   assign dev_wstrb   = dev_wstrb_r;

endmodule
